// File: rtl/julia_mem_pkg.sv
// Shared types and sizing helpers for the Julia pixel write path.
package julia_mem_pkg;

  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_FIFO_DEPTH = 4;

  // Pointer width for a power-of-two FIFO; depth 1 would still need one bit.
  function automatic int fifo_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Occupancy counter must be able to represent the full depth itself.
  function automatic int fifo_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam int FIFO_PTR_W = fifo_ptr_w(DEF_FIFO_DEPTH);
  localparam int FIFO_CNT_W = fifo_cnt_w(DEF_FIFO_DEPTH);

  // One buffered memory write at the default bus widths.
  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } wr_entry_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first request at or after ptr+1.
module rr_arbiter
  import julia_mem_pkg::*;
#(
  parameter  int N     = 16,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             en,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid
);

  // Scan channels starting just past the last winner, wrapping modulo N.
  always_comb begin
    int idx;
    logic [IDX_W-1:0] sel;
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    idx       = 0;
    sel       = '0;
    if (en) begin
      for (int k = 1; k <= N; k++) begin
        idx = (int'(ptr) + k) % N;
        sel = IDX_W'(idx);
        if (!gnt_valid && req[sel]) begin
          gnt_valid = 1'b1;
          gnt_idx   = sel;
          gnt[sel]  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/julia_write_arbiter.sv
// Gathers finished pixels from the Julia engines and streams them to memory.
module julia_write_arbiter
  import julia_mem_pkg::*;
#(
  parameter int NUM_JULIA  = 16,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             enable,
  input  logic [NUM_JULIA-1:0]             done,
  input  logic [ADDR_W*NUM_JULIA-1:0]      cataddresses,
  input  logic [DATA_W*NUM_JULIA-1:0]      catpixels,
  input  logic                             wait_request,
  output logic [NUM_JULIA-1:0]             free,
  output logic [ADDR_W-1:0]                write_address,
  output logic [DATA_W-1:0]                write_data,
  output logic                             write_enable,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count,
  output logic [31:0]                      write_count,
  output logic                             busy
);

  localparam int ARB_W = (NUM_JULIA > 1) ? $clog2(NUM_JULIA) : 1;
  localparam int PTR_W = fifo_ptr_w(FIFO_DEPTH);
  localparam int CNT_W = fifo_cnt_w(FIFO_DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic [NUM_JULIA-1:0] free_q, free_d;
  logic [ARB_W-1:0]     arb_ptr_q, arb_ptr_d;
  entry_t               mem_q [FIFO_DEPTH];
  entry_t               mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  entry_t               head_q, head_d;
  logic [31:0]          write_count_q, write_count_d;

  logic [NUM_JULIA-1:0] eligible;
  logic [NUM_JULIA-1:0] gnt;
  logic [ARB_W-1:0]     gnt_idx;
  logic                 gnt_valid;
  logic                 not_full;
  logic                 push;
  logic                 pop;
  entry_t               push_entry;

  // The ack cycle is masked so an engine still showing done is not re-granted.
  assign eligible = done & ~free_q;
  assign not_full = (count_q < CNT_W'(FIFO_DEPTH));
  assign push     = gnt_valid;
  assign pop      = (count_q != '0) && !wait_request;

  assign push_entry.addr = cataddresses[gnt_idx*ADDR_W +: ADDR_W];
  assign push_entry.data = catpixels[gnt_idx*DATA_W +: DATA_W];

  rr_arbiter #(.N(NUM_JULIA)) u_arb (
    .req       (eligible),
    .ptr       (arb_ptr_q),
    .en        (enable && not_full),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  // Capture side: one-cycle ack pulse and round-robin pointer advance.
  always_comb begin
    free_d    = gnt;
    arb_ptr_d = push ? gnt_idx : arb_ptr_q;
  end

  // FIFO storage, pointers, occupancy and accepted-write counter.
  always_comb begin
    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_entry;
    end
    wr_ptr_d      = wr_ptr_q + PTR_W'(push);
    rd_ptr_d      = rd_ptr_q + PTR_W'(pop);
    count_d       = count_q + CNT_W'(push) - CNT_W'(pop);
    write_count_d = write_count_q + 32'(pop);
  end

  // Registered head: next entry is ready the cycle after an accept, and a
  // push into an empty (or emptying) FIFO lands directly in the head.
  always_comb begin
    head_d = head_q;
    if (pop && (count_q > CNT_W'(1))) begin
      head_d = mem_q[rd_ptr_q + PTR_W'(1)];
    end else if (push && ((count_q == '0) || (pop && (count_q == CNT_W'(1))))) begin
      head_d = push_entry;
    end
  end

  // State register; reset discards the FIFO and restarts the search at channel 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      free_q        <= '0;
      arb_ptr_q     <= ARB_W'(NUM_JULIA - 1);
      mem_q         <= '{default: '0};
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      head_q        <= '0;
      write_count_q <= '0;
    end else begin
      free_q        <= free_d;
      arb_ptr_q     <= arb_ptr_d;
      mem_q         <= mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      head_q        <= head_d;
      write_count_q <= write_count_d;
    end
  end

  assign free          = free_q;
  assign write_address = head_q.addr;
  assign write_data    = head_q.data;
  assign write_enable  = (count_q != '0);
  assign fifo_count    = count_q;
  assign write_count   = write_count_q;
  assign busy          = (count_q != '0) || (free_q != '0);

endmodule

// File: tb/tb_julia_write_arbiter.sv
// Self-checking bench: queue-based reference model plus directed scenarios.
module tb_julia_write_arbiter;
  import julia_mem_pkg::*;

  localparam int NJ    = 16;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              enable = 1'b1;
  logic [NJ-1:0]     done = '0;
  logic [AW*NJ-1:0]  cataddresses = '0;
  logic [DW*NJ-1:0]  catpixels = '0;
  logic              wait_request = 1'b0;
  logic [NJ-1:0]     free;
  logic [AW-1:0]     write_address;
  logic [DW-1:0]     write_data;
  logic              write_enable;
  logic [2:0]        fifo_count;
  logic [31:0]       write_count;
  logic              busy;

  int tests = 0;
  int failures = 0;
  bit checkEn = 1'b0;
  bit autoDrop = 1'b0;

  julia_write_arbiter #(
    .NUM_JULIA(NJ), .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .done(done),
    .cataddresses(cataddresses), .catpixels(catpixels),
    .wait_request(wait_request), .free(free),
    .write_address(write_address), .write_data(write_data),
    .write_enable(write_enable), .fifo_count(fifo_count),
    .write_count(write_count), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of pending writes, the last grant, and the pointer.
  wr_entry_t   mq[$];
  wr_entry_t   mEntry;
  int          mFree = -1;
  int          mPtr = NJ - 1;
  logic [31:0] mWrites = '0;
  int          mGrant;
  int          mIdx;
  logic [NJ-1:0] expFree;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      mFree   = -1;
      mPtr    = NJ - 1;
      mWrites = '0;
    end else begin
      mGrant = -1;
      if (enable && (mq.size() < DEPTH)) begin
        for (int k = 1; k <= NJ; k++) begin
          mIdx = (mPtr + k) % NJ;
          if ((mGrant < 0) && done[mIdx] && (mIdx != mFree)) mGrant = mIdx;
        end
      end
      if ((mq.size() > 0) && !wait_request) begin
        void'(mq.pop_front());
        mWrites = mWrites + 32'd1;
      end
      if (mGrant >= 0) begin
        mEntry.addr = cataddresses[mGrant*AW +: AW];
        mEntry.data = catpixels[mGrant*DW +: DW];
        mq.push_back(mEntry);
        mPtr = mGrant;
      end
      mFree = mGrant;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle, compare the DUT against the model away from the clock edge.
  always @(negedge clk) begin
    if (checkEn) begin
      expFree = '0;
      if (mFree >= 0) expFree[mFree] = 1'b1;
      checkOutput("model_free", 64'(free), 64'(expFree));
      checkOutput("model_we", 64'(write_enable), 64'(mq.size() != 0));
      checkOutput("model_count", 64'(fifo_count), 64'(mq.size()));
      checkOutput("model_wcount", 64'(write_count), 64'(mWrites));
      checkOutput("model_busy", 64'(busy), 64'((mq.size() != 0) || (mFree >= 0)));
      if (mq.size() > 0) begin
        checkOutput("model_addr", 64'(write_address), 64'(mq[0].addr));
        checkOutput("model_data", 64'(write_data), 64'(mq[0].data));
      end
    end
  end

  // Advance one cycle; engines optionally drop done once they see their ack.
  task automatic applyStimulus();
    @(negedge clk);
    #1;
    if (autoDrop) done = done & ~free;
  endtask

  task automatic setChan(input int i, input logic [31:0] a, input logic [31:0] p);
    cataddresses[i*AW +: AW] = a;
    catpixels[i*DW +: DW]    = p;
  endtask

  task automatic doReset();
    rst  = 1'b1;
    done = '0;
    applyStimulus();
    rst = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_free"}, 64'(free), 64'd0);
    checkOutput({tag, "_we"}, 64'(write_enable), 64'd0);
    checkOutput({tag, "_addr"}, 64'(write_address), 64'd0);
    checkOutput({tag, "_data"}, 64'(write_data), 64'd0);
    checkOutput({tag, "_count"}, 64'(fifo_count), 64'd0);
    checkOutput({tag, "_wcount"}, 64'(write_count), 64'd0);
    checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int pulses;

    // Reset state.
    doReset();
    checkEn = 1'b1;
    checkAllZero("reset");

    // Single channel 3.
    autoDrop = 1'b1;
    setChan(3, 32'h100, 32'hABCD);
    done[3] = 1'b1;
    applyStimulus();
    checkOutput("single_free", 64'(free), 64'h0008);
    checkOutput("single_we", 64'(write_enable), 64'd1);
    checkOutput("single_addr", 64'(write_address), 64'h100);
    checkOutput("single_data", 64'(write_data), 64'hABCD);
    checkOutput("single_count", 64'(fifo_count), 64'd1);
    applyStimulus();
    checkOutput("single_free_off", 64'(free), 64'd0);
    checkOutput("single_count_after", 64'(fifo_count), 64'd0);
    checkOutput("single_wcount", 64'(write_count), 64'd1);

    // All sixteen at once: strict 0..15 order, one per cycle.
    doReset();
    for (int i = 0; i < NJ; i++) setChan(i, 32'h1000 + 32'(i) * 4, 32'h5000 + 32'(i));
    done = '1;
    for (int k = 0; k < NJ; k++) begin
      applyStimulus();
      checkOutput("all16_free", 64'(free), 64'(1) << k);
      checkOutput("all16_addr", 64'(write_address), 64'h1000 + 64'(k) * 4);
    end
    applyStimulus();
    checkOutput("all16_free_end", 64'(free), 64'd0);
    checkOutput("all16_wcount", 64'(write_count), 64'd16);

    // Stall for five cycles on the first write.
    doReset();
    wait_request = 1'b1;
    setChan(1, 32'hA1, 32'hD1);
    setChan(2, 32'hA2, 32'hD2);
    done = 16'h0006;
    for (int k = 0; k < 5; k++) begin
      applyStimulus();
      checkOutput("stall_we", 64'(write_enable), 64'd1);
      checkOutput("stall_addr", 64'(write_address), 64'hA1);
      checkOutput("stall_data", 64'(write_data), 64'hD1);
    end
    wait_request = 1'b0;
    applyStimulus();
    checkOutput("stall_next_addr", 64'(write_address), 64'hA2);
    checkOutput("stall_next_data", 64'(write_data), 64'hD2);
    checkOutput("stall_wcount", 64'(write_count), 64'd1);
    for (int k = 0; k < 3; k++) applyStimulus();

    // FIFO saturation with eight requesters and memory stalled.
    doReset();
    wait_request = 1'b1;
    for (int i = 0; i < 8; i++) setChan(i, 32'h2000 + 32'(i), 32'h7000 + 32'(i));
    done = 16'h00FF;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      applyStimulus();
      pulses += $countones(free);
    end
    checkOutput("sat_pulses", 64'(pulses), 64'd4);
    checkOutput("sat_count", 64'(fifo_count), 64'd4);
    checkOutput("sat_pending", 64'(done), 64'h00F0);
    wait_request = 1'b0;
    for (int k = 0; k < 20; k++) applyStimulus();
    checkOutput("sat_wcount", 64'(write_count), 64'd8);
    checkOutput("sat_done_left", 64'(done), 64'd0);

    // Enable dropped with three buffered and two still requesting.
    doReset();
    wait_request = 1'b1;
    done = 16'h0067;
    for (int k = 0; k < 3; k++) applyStimulus();
    checkOutput("en_count3", 64'(fifo_count), 64'd3);
    enable = 1'b0;
    wait_request = 1'b0;
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      applyStimulus();
      pulses += $countones(free);
    end
    checkOutput("en_no_pulses", 64'(pulses), 64'd0);
    checkOutput("en_wcount", 64'(write_count), 64'd3);
    checkOutput("en_busy", 64'(busy), 64'd0);
    enable = 1'b1;
    applyStimulus();
    checkOutput("en_resume5", 64'(free), 64'h0020);
    applyStimulus();
    checkOutput("en_resume6", 64'(free), 64'h0040);
    for (int k = 0; k < 3; k++) applyStimulus();

    // Reset while three entries wait on a stalled memory.
    doReset();
    wait_request = 1'b1;
    done = 16'h0007;
    for (int k = 0; k < 3; k++) applyStimulus();
    checkOutput("rst_pre_count", 64'(fifo_count), 64'd3);
    rst = 1'b1;
    done = 16'h0220;
    applyStimulus();
    checkAllZero("midrst");
    rst = 1'b0;
    applyStimulus();
    checkOutput("rst_first_grant", 64'(free), 64'h0020);

    // Randomised traffic against the model.
    autoDrop = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NJ; i++) begin
        if (free[i] && ($urandom_range(3) != 0)) done[i] = 1'b0;
        else if (!done[i] && ($urandom_range(3) == 0)) done[i] = 1'b1;
        setChan(i, $urandom, $urandom);
      end
      enable       = ($urandom_range(9) != 0);
      wait_request = ($urandom_range(9) < 3);
      rst          = ($urandom_range(199) == 0);
      applyStimulus();
    end
    rst = 1'b0;
    enable = 1'b0;
    wait_request = 1'b0;
    for (int k = 0; k < 10; k++) applyStimulus();
    checkOutput("drain_busy", 64'(busy), 64'd0);
    checkOutput("drain_count", 64'(fifo_count), 64'd0);

    checkEn = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/julia_write_arbiter.md
Name: julia_write_arbiter

Overview:
Parametrised successor to the Julia pixel memory write controller. Collects finished {address, pixel} pairs from NUM_JULIA engines using a round-robin arbiter, buffers them in a small FIFO, and drains the FIFO to an Avalon-MM style write master, issuing back-to-back writes. Sits between the Julia engine array and the frame-buffer memory interface.

Parameters:
NUM_JULIA, 16, number of Julia engine channels (2..64)
ADDR_W, 32, write address width
DATA_W, 32, pixel data width
FIFO_DEPTH, 4, buffered write entries (power of 2, >=2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
enable  in  1  1 = accept new requests; 0 = stop granting, keep draining FIFO
done  in  NUM_JULIA  per-channel "result ready" level
cataddresses  in  ADDR_W*NUM_JULIA  concatenated channel addresses; channel i at [i*ADDR_W +: ADDR_W]
catpixels  in  DATA_W*NUM_JULIA  concatenated channel pixels; same slicing
wait_request  in  1  memory stall
free  out  NUM_JULIA  one-hot, one-cycle capture acknowledge
write_address  out  ADDR_W  memory write address
write_data  out  DATA_W  memory write data
write_enable  out  1  write request
fifo_count  out  $clog2(FIFO_DEPTH+1)  current occupancy
write_count  out  32  writes accepted by memory (wraps modulo 2^32)
busy  out  1  FIFO non-empty or free pulse in flight

Behaviour:
- All state updates on the posedge of clk. rst is sampled synchronously. On reset: free=0, write_enable=0, write_address=0, write_data=0, fifo_count=0, write_count=0, busy=0, and arb_ptr=NUM_JULIA-1 so the first search starts at channel 0.
- Eligible request: done[i]=1 and free[i]=0 in the same cycle. This masks the ack cycle, so an engine that drops done on the cycle after free is never granted twice.
- Grant: in a cycle with enable=1, fifo_count<FIFO_DEPTH and at least one eligible request, grant exactly one channel g. g is the first eligible index at or after (arb_ptr+1) mod NUM_JULIA.
- At the clock edge that ends a grant cycle:
  - push {cataddresses[g], catpixels[g]} into the FIFO;
  - set free=one-hot(g) for exactly one cycle;
  - set arb_ptr=g.
- With no grant, free=0.
- Push is evaluated against fifo_count at the start of the cycle. There is no full-bypass: when full, no grant, even if a pop occurs in the same cycle.
- Master side:
  - write_enable=1 whenever the FIFO is non-empty.
  - write_address and write_data come from the FIFO head, held through a registered head.
  - A write is accepted in a cycle with write_enable=1 and wait_request=0. On acceptance: pop, write_count+1.
  - While wait_request=1, address, data and enable are held stable.
  - The next entry is presented in the cycle after acceptance, so there are no dead cycles between writes.
- Simultaneous push and pop: fifo_count is unchanged and pointers wrap modulo FIFO_DEPTH.
- Latency: done[i] rises in cycle 0 with an empty FIFO → free[i]=1, write_enable=1 and fifo_count=1 in cycle 1. With wait_request=0 the write is accepted in cycle 1 and fifo_count=0 in cycle 2.
- enable=0: the current FIFO contents still drain, no new free pulses are issued, and arb_ptr holds.
- Reset mid-operation: FIFO contents are discarded and write_enable is 0 on the cycle after rst is sampled. This is the only permitted Avalon hold violation.
- Inputs on an ungranted channel may change freely. Captured values are those present in the grant cycle.
- busy = (fifo_count!=0) | (free!=0).

Decomposition:
- Package julia_mem_pkg:
  - FIFO pointer and count width constants derived from FIFO_DEPTH;
  - a packed struct wr_entry_t {addr, data}.
- Sub-module rr_arbiter:
  - parameter N;
  - inputs req[N], ptr, en;
  - outputs gnt one-hot, gnt_idx, gnt_valid;
  - purely combinational.
- The FIFO and master logic stay inline.

Test Plan:
- Single channel 3 asserts done with addr 0x100, pixel 0xABCD, wait_request=0 → free[3] high for one cycle in cycle 1; write 0x100/0xABCD issued in cycle 1; write_count=1.
- All 16 done asserted together, each engine dropping done after its free, wait_request=0 → grants in order 0,1,…,15, one per cycle; 16 writes in matching order; no channel granted twice.
- wait_request held high for 5 cycles on the first write → write_address, write_data and write_enable stay constant for all 5 cycles; the second entry appears on the cycle after wait_request falls.
- wait_request held high, 8 channels requesting, FIFO_DEPTH=4 → exactly 4 free pulses; fifo_count saturates at 4; remaining done signals stay pending until pops begin.
- enable dropped with 3 entries buffered and 2 channels still requesting → 3 writes complete, no further free pulses, busy falls to 0. Raising enable resumes grants starting after the last-granted index.
- rst asserted while fifo_count=3 and wait_request=1 → next cycle all outputs are 0; the following first grant goes to the lowest eligible index starting from channel 0.
